// File: rtl/multi_phase_traffic_ctrl.sv
// Multi-direction traffic signal controller with a round-robin green, a pedestrian walk phase
// and a maintenance flash mode. All phase timing is counted in prescaled ticks.
module multi_phase_traffic_ctrl #(
    parameter int N_DIR     = 4,
    parameter int TICK_DIV  = 50_000_000,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_DIR-1:0]           sense,
    input  logic                       ped_req,
    input  logic                       flash,
    output logic [3*N_DIR-1:0]         lights,
    output logic                       walk,
    output logic [$clog2(N_DIR)-1:0]   active_dir,
    output logic [2:0]                 phase
);

    localparam int DW   = $clog2(N_DIR);
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int T1   = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
    localparam int T2   = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
    localparam int MAXT = (T1 > T2) ? T1 : T2;
    localparam int TW   = $clog2(MAXT) + 1;
    localparam int EW   = TW + 1;

    localparam logic [2:0] P_GREEN  = 3'd0;
    localparam logic [2:0] P_YELLOW = 3'd1;
    localparam logic [2:0] P_ALLRED = 3'd2;
    localparam logic [2:0] P_WALK   = 3'd3;
    localparam logic [2:0] P_FLASH  = 3'd4;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [EW-1:0] GMIN_E     = EW'(GREEN_MIN);
    localparam logic [EW-1:0] GMAX_E     = EW'(GREEN_MAX);
    localparam logic [EW-1:0] YEL_E      = EW'(YELLOW_T);
    localparam logic [EW-1:0] AR_E       = EW'(ALLRED_T);
    localparam logic [EW-1:0] WALK_E     = EW'(WALK_T);
    localparam logic [DW-1:0] DIR_LAST   = DW'(N_DIR - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    phase_q, phase_d;
    logic [DW-1:0] dir_q, dir_d;
    logic          ped_q, ped_d;
    logic          fred_q, fred_d;   // flash lamp state: 0 = yellow, 1 = red

    logic          tick;
    logic [EW-1:0] elapsed;
    logic          own_sense;
    logic          other;
    logic [N_DIR-1:0] sense_sh;

    // Round-robin search starting after d; falls back to d+1 when nothing is sensed.
    function automatic logic [DW-1:0] next_dir(input logic [DW-1:0] d, input logic [N_DIR-1:0] s);
        logic [DW-1:0]    r;
        logic [N_DIR-1:0] t;
        int               idx;
        idx = int'(d) + 1;
        if (idx >= N_DIR) idx = idx - N_DIR;
        r = DW'(idx);
        for (int k = N_DIR; k >= 1; k--) begin
            idx = int'(d) + k;
            if (idx >= N_DIR) idx = idx - N_DIR;
            t = s >> idx;
            if (t[0]) r = DW'(idx);
        end
        return r;
    endfunction

    function automatic logic [2:0] lamp(input logic [2:0] ph, input logic mine, input logic fred);
        case (ph)
            P_GREEN:  lamp = mine ? 3'b001 : 3'b100;
            P_YELLOW: lamp = mine ? 3'b010 : 3'b100;
            P_FLASH:  lamp = fred ? 3'b100 : 3'b010;
            default:  lamp = 3'b100;
        endcase
    endfunction

    assign tick      = (presc_q == PRESC_LAST);
    assign elapsed   = {1'b0, timer_q} + EW'(1);
    assign sense_sh  = sense >> dir_q;
    assign own_sense = sense_sh[0];
    assign other     = (|(sense & ~(N_DIR'(1) << dir_q))) | ped_q;

    always_comb begin
        phase_d = phase_q;
        dir_d   = dir_q;
        fred_d  = fred_q;
        if (flash) begin
            phase_d = P_FLASH;
            if (phase_q != P_FLASH) fred_d = 1'b0;
            else if (tick)          fred_d = ~fred_q;
        end else if (tick) begin
            case (phase_q)
                P_GREEN:
                    if (elapsed >= GMIN_E && other && (!own_sense || elapsed >= GMAX_E))
                        phase_d = P_YELLOW;
                P_YELLOW:
                    if (elapsed >= YEL_E) phase_d = P_ALLRED;
                P_ALLRED:
                    if (elapsed >= AR_E) begin
                        if (ped_q) begin
                            phase_d = P_WALK;
                        end else begin
                            phase_d = P_GREEN;
                            dir_d   = next_dir(dir_q, sense);
                        end
                    end
                P_WALK:
                    if (elapsed >= WALK_E) phase_d = P_ALLRED;
                P_FLASH: begin
                    phase_d = P_ALLRED;
                    dir_d   = DIR_LAST;
                end
                default: phase_d = P_ALLRED;
            endcase
        end
    end

    // A request arriving in the WALK-entry cycle survives the clear.
    assign ped_d   = ped_req | (ped_q & ~((phase_d == P_WALK) && (phase_q != P_WALK)));
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    always_comb begin
        timer_d = timer_q;
        if (phase_d != phase_q)          timer_d = '0;
        else if (tick && timer_q != '1)  timer_d = timer_q + TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            timer_q <= '0;
            phase_q <= P_GREEN;
            dir_q   <= '0;
            ped_q   <= 1'b0;
            fred_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            timer_q <= timer_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            ped_q   <= ped_d;
            fred_q  <= fred_d;
        end
    end

    for (genvar g = 0; g < N_DIR; g++) begin : g_lamp
        assign lights[3*g +: 3] = lamp(phase_q, DW'(g) == dir_q, fred_q);
    end

    assign walk       = (phase_q == P_WALK);
    assign active_dir = dir_q;
    assign phase      = phase_q;

endmodule
